universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//   Parametrised command-driven shift register, the successor to the single-bit bidirectional shifter.
//   Takes one command per transaction over a valid/ready handshake: parallel load, logical shift L/R,
//   rotate L/R or arithmetic shift right, repeated cmd_cnt times at one bit per enabled cycle.
//   Streams each bit shifted out on sout. Sits between serial links and parallel datapath registers.
// PARAMETERS
//   WIDTH  8  register width in bits, >= 2
//   CNT_W  4  width of cmd_cnt; max shifts per command = 2**CNT_W-1
// PORTS
//   clk         in   1      clock; all state updates on rising edge
//   rst         in   1      synchronous reset, active-high
//   en          in   1      shift enable; 0 stalls an in-progress shift sequence
//   cmd_valid   in   1      command present
//   cmd_ready   out  1      block can accept; = (state==IDLE), combinational from state only
//   cmd_op      in   3      0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 reserved (=NOP)
//   cmd_cnt     in   CNT_W  number of single-bit shifts (ignored for NOP/LOAD)
//   load_data   in   WIDTH  parallel data for LOAD
//   sin         in   1      serial input bit for SHL/SHR, sampled on every executed shift
//   q           out  WIDTH  register contents
//   sout        out  1      bit shifted/rotated out by the most recent executed shift
//   sout_valid  out  1      1-cycle pulse: sout updated by the shift on the previous edge
//   busy        out  1      = (state==SHIFT)
//   done        out  1      1-cycle pulse: command completed
// BEHAVIOUR
//   Reset (rst=1 at edge): q=0, sout=0, sout_valid=0, done=0, state=IDLE. Takes precedence over
//     everything. Aborts any sequence mid-flight with no done pulse.
//   FSM: IDLE, SHIFT. Accept = cmd_valid & cmd_ready at a rising edge; inputs latched at that edge.
//   IDLE accept:
//     NOP, op 7, or shift op with cmd_cnt=0 -> q unchanged; done=1 next cycle; stay IDLE.
//     LOAD -> q<=load_data on the accept edge; done=1 next cycle; stay IDLE; en not required.
//     Shift op, cmd_cnt=N>=1 -> latch op, remaining<=N, go to SHIFT; q unchanged on this edge.
//   SHIFT, at each edge with en=1: perform one shift, remaining--, sout<=exiting bit, sout_valid=1.
//     SHL: q<={q[W-2:0],sin}, sout=q[W-1].   SHR: q<={sin,q[W-1:1]}, sout=q[0].
//     ROL: q<={q[W-2:0],q[W-1]}, sout=q[W-1]. ROR: q<={q[0],q[W-1:1]}, sout=q[0].
//     ASR: q<={q[W-1],q[W-1:1]}, sout=q[0]; sin ignored.
//     On the shift taking remaining 1->0: go to IDLE; done=1 next cycle.
//   SHIFT with en=0: q, remaining, sout hold; sout_valid=0. No timeout.
//   Latency: N-shift command = accept edge + N enabled edges; done high the cycle after the last shift.
//   cmd_ready rises in that same cycle, so a new command may be accepted while done=1.
//     Back-to-back commands incur no bubble.
//   cmd_valid while busy: ignored. Master holds the command until cmd_ready.
//   done and sout_valid are registered and deasserted in all other cycles.
//   sout holds its last value between shifts.
//   cmd_cnt may exceed WIDTH: shifts keep going (e.g. SHL of 10 with W=8 leaves only sin bits).
// TESTING
//   rst then LOAD 0xA5 -> q=0xA5 at the next edge; done=1 one cycle; busy never high.
//   SHL cnt=3, sin=1,0,1 on successive shift cycles, q=0xA5 -> q=0x2D;
//     sout=1,0,1 with sout_valid 3 cycles; done on the 4th cycle after accept.
//   ASR cnt=2 on 0x80 -> 0xE0; ROR cnt=8 on 0x3C -> 0x3C; ROL cnt=1 on 0x81 -> 0x03, sout=1.
//   SHR cnt=4 with en low for 2 cycles mid-sequence -> completes 2 cycles late; q correct;
//     no sout_valid while stalled.
//   rst asserted during the 2nd shift of SHL cnt=5 -> q=0 next cycle, state IDLE, no done;
//     cmd_valid during busy not accepted.
//   Back-to-back: LOAD accepted in the done cycle of a prior ROL; shift with cnt=0 -> done, q unchanged.

Source files
------------

// File: rtl/universal_shift_register_if.sv
// Command channel of the universal shift register: one command per valid/ready handshake.
interface universal_shift_register_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] load_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_cnt,
    output load_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_cnt,
    input  load_data,
    output cmd_ready
  );
endinterface

// File: rtl/universal_shift_register.sv
// Command-driven shift register: parallel load, logical/rotate/arithmetic shifts repeated
// cmd_cnt times at one bit per enabled cycle, with the exiting bit streamed on sout.
module universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        sin,
  universal_shift_register_if.slave   cmd,
  output logic [WIDTH-1:0]            q,
  output logic                        sout,
  output logic                        sout_valid,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpLoad = 3'd1,
    OpShl  = 3'd2,
    OpShr  = 3'd3,
    OpRol  = 3'd4,
    OpRor  = 3'd5,
    OpAsr  = 3'd6,
    OpRsvd = 3'd7
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             done_q, done_d;
  op_e              cmd_op;
  logic             accept;

  assign cmd_op        = op_e'(cmd.cmd_op);
  assign cmd.cmd_ready = (state_q == StIdle);
  assign accept        = cmd.cmd_valid && (state_q == StIdle);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rem_d        = rem_q;
    q_d          = q_q;
    sout_d       = sout_q;
    sout_valid_d = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (cmd_op)
            OpLoad: begin
              q_d    = cmd.load_data;
              done_d = 1'b1;
            end
            OpShl, OpShr, OpRol, OpRor, OpAsr: begin
              // A zero count completes immediately, like a NOP.
              if (cmd.cmd_cnt == '0) begin
                done_d = 1'b1;
              end else begin
                op_d    = cmd_op;
                rem_d   = cmd.cmd_cnt;
                state_d = StShift;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end

      StShift: begin
        if (en) begin
          sout_valid_d = 1'b1;
          rem_d        = rem_q - CNT_W'(1);
          case (op_q)
            OpShl: begin
              q_d    = {q_q[WIDTH-2:0], sin};
              sout_d = q_q[WIDTH-1];
            end
            OpShr: begin
              q_d    = {sin, q_q[WIDTH-1:1]};
              sout_d = q_q[0];
            end
            OpRol: begin
              q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              sout_d = q_q[WIDTH-1];
            end
            OpRor: begin
              q_d    = {q_q[0], q_q[WIDTH-1:1]};
              sout_d = q_q[0];
            end
            OpAsr: begin
              q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
              sout_d = q_q[0];
            end
            default: begin
              q_d    = q_q;
              sout_d = sout_q;
            end
          endcase
          if (rem_q == CNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= OpNop;
      rem_q        <= '0;
      q_q          <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rem_q        <= rem_d;
      q_q          <= q_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
    end
  end

  assign q          = q_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = (state_q == StShift);
  assign done       = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed and randomized bench for universal_shift_register against an arithmetic reference model.
module tb_universal_shift_register;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;
  localparam int          MODV = 2 ** W;
  localparam int          TOP  = 2 ** (W - 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         sin;
  logic [W-1:0] q;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  int mq       = 0;
  int msout    = 0;

  universal_shift_register_if #(.WIDTH(W), .CNT_W(CW)) cmd_if ();

  universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sin        (sin),
    .cmd        (cmd_if.slave),
    .q          (q),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: register value as an integer in [0, 2**W), shifts as multiply/divide.
  function automatic void model_shift(input int op, input int s);
    case (op)
      2: begin msout = mq / TOP; mq = (mq * 2 + s) % MODV; end
      3: begin msout = mq % 2;   mq = mq / 2 + s * TOP; end
      4: begin msout = mq / TOP; mq = (mq * 2) % MODV + msout; end
      5: begin msout = mq % 2;   mq = mq / 2 + msout * TOP; end
      6: begin msout = mq % 2;   mq = mq / 2 + ((mq >= TOP) ? TOP : 0); end
      default: ;
    endcase
  endfunction

  function automatic bit is_shift(input int op, input int cnt);
    return (op >= 2) && (op <= 6) && (cnt != 0);
  endfunction

  task automatic do_cmd(input int op, input int cnt, input int data, input logic [15:0] sin_pat,
                        input bit rand_en, input int stall_at, input int stall_len);
    int done_shifts;
    int stalled;
    int guard;
    bit e;
    check("ready_before_cmd", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'(op);
    cmd_if.cmd_cnt   = CW'(cnt);
    cmd_if.load_data = W'(data);
    en               = 1'($urandom_range(0, 1));
    sin              = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    if (op == 1) mq = data % MODV;
    if (!is_shift(op, cnt)) begin
      check("imm_done", 32'(done), 32'd1);
      check("imm_busy", 32'(busy), 32'd0);
      check("imm_q", 32'(q), 32'(mq));
      check("imm_sout_valid", 32'(sout_valid), 32'd0);
      return;
    end
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
    check("accept_q", 32'(q), 32'(mq));
    done_shifts = 0;
    stalled     = 0;
    guard       = 0;
    while (done_shifts < cnt && guard < 200) begin
      guard++;
      if (rand_en) e = ($urandom_range(0, 3) != 0);
      else if (done_shifts == stall_at && stalled < stall_len) begin
        e = 1'b0;
        stalled++;
      end else e = 1'b1;
      en  = e;
      sin = rand_en ? 1'($urandom_range(0, 1)) : sin_pat[done_shifts];
      // Commands offered while busy must be ignored.
      if ($urandom_range(0, 3) == 0) begin
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd1;
        cmd_if.load_data = W'($urandom);
      end
      @(posedge clk);
      #1;
      cmd_if.cmd_valid = 1'b0;
      if (e) begin
        model_shift(op, int'(sin));
        done_shifts++;
        check("shift_sout_valid", 32'(sout_valid), 32'd1);
        check("shift_sout", 32'(sout), 32'(msout));
      end else begin
        check("stall_sout_valid", 32'(sout_valid), 32'd0);
        check("stall_sout_hold", 32'(sout), 32'(msout));
      end
      check("shift_q", 32'(q), 32'(mq));
      if (done_shifts < cnt) begin
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_done", 32'(done), 32'd0);
      end else begin
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_ready", 32'(cmd_if.cmd_ready), 32'd1);
      end
    end
    check("shift_count_in_budget", 32'(done_shifts), 32'(cnt));
  endtask

  initial begin
    rst              = 1'b1;
    en               = 1'b0;
    sin              = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = '0;
    cmd_if.cmd_cnt   = '0;
    cmd_if.load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", 32'(q), 32'd0);
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_sout_valid", 32'(sout_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    rst = 1'b0;

    do_cmd(1, 0, 'hA5, 16'h0, 1'b0, -1, 0);
    check("load_a5", 32'(q), 32'h0000_00A5);
    do_cmd(2, 3, 0, 16'b101, 1'b0, -1, 0);
    check("shl3_result", 32'(q), 32'h0000_002D);

    do_cmd(1, 0, 'h80, 16'h0, 1'b0, -1, 0);
    do_cmd(6, 2, 0, 16'h0, 1'b0, -1, 0);
    check("asr2_result", 32'(q), 32'h0000_00E0);

    do_cmd(1, 0, 'h3C, 16'h0, 1'b0, -1, 0);
    do_cmd(5, 8, 0, 16'h0, 1'b0, -1, 0);
    check("ror8_result", 32'(q), 32'h0000_003C);

    do_cmd(1, 0, 'h81, 16'h0, 1'b0, -1, 0);
    do_cmd(4, 1, 0, 16'h0, 1'b0, -1, 0);
    check("rol1_result", 32'(q), 32'h0000_0003);
    check("rol1_sout", 32'(sout), 32'd1);
    // Accepted in the done cycle of the ROL: no bubble.
    do_cmd(1, 0, 'h5A, 16'h0, 1'b0, -1, 0);
    check("b2b_load", 32'(q), 32'h0000_005A);
    do_cmd(3, 0, 0, 16'h0, 1'b0, -1, 0);
    check("cnt0_q", 32'(q), 32'h0000_005A);
    do_cmd(0, 5, 0, 16'h0, 1'b0, -1, 0);
    do_cmd(7, 5, 0, 16'h0, 1'b0, -1, 0);
    check("nop_q", 32'(q), 32'h0000_005A);

    do_cmd(1, 0, 'hF0, 16'h0, 1'b0, -1, 0);
    do_cmd(3, 4, 0, 16'h0, 1'b0, 2, 2);
    check("shr4_stall_result", 32'(q), 32'h0000_000F);

    // Reset during the second shift of SHL cnt=5.
    do_cmd(1, 0, 'hC3, 16'h0, 1'b0, -1, 0);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'd2;
    cmd_if.cmd_cnt   = CW'(5);
    en               = 1'b1;
    sin              = 1'b1;
    @(posedge clk);
    #1;
    check("abort_accept_busy", 32'(busy), 32'd1);
    cmd_if.cmd_op    = 3'd1;
    cmd_if.load_data = 8'hFF;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    model_shift(2, 1);
    check("abort_shift1_q", 32'(q), 32'(mq));
    check("abort_shift1_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    en    = 1'b0;
    mq    = 0;
    msout = 0;
    check("abort_q", 32'(q), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sout", 32'(sout), 32'd0);
    check("abort_sout_valid", 32'(sout_valid), 32'd0);
    @(posedge clk);
    #1;
    check("abort_no_late_done", 32'(done), 32'd0);
    check("abort_idle_q", 32'(q), 32'd0);

    for (int i = 0; i < 60; i++) begin
      do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 255)), 16'h0, 1'b1, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
